// File: rtl/pwm_pkg.sv
// Shared types and defaults for the pwm_gen waveform generator.
// Holds the FSM state encoding and the default count width.
package pwm_pkg;

  localparam int unsigned PwmWidthDefault = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_if.sv
// Configuration channel for pwm_gen: high/low counts offered on a valid/ready handshake.
// The source drives through the master modport; the generator consumes through slave.
interface pwm_if
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PwmWidthDefault
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_pos;
  logic [WIDTH-1:0] cfg_neg;

  modport master (
    output cfg_valid,
    output cfg_pos,
    output cfg_neg,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_pos,
    input  cfg_neg,
    output cfg_ready
  );

endinterface

// File: rtl/pwm_cfg_buf.sv
// Single-entry pending configuration register with valid/ready intake.
// The held entry is released to the generator only on a period boundary.
module pwm_cfg_buf
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PwmWidthDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_if.slave             cfg,
  input  logic             i_boundary,
  output logic             o_apply,
  output logic             o_pend_full,
  output logic [WIDTH-1:0] o_pend_pos,
  output logic [WIDTH-1:0] o_pend_neg
);

  logic             r_pend_full;
  logic [WIDTH-1:0] r_pend_pos;
  logic [WIDTH-1:0] r_pend_neg;
  logic             w_accept;

  // Accept needs an empty slot and apply needs a full one, so they never coincide.
  assign w_accept      = cfg.cfg_valid & ~r_pend_full;
  assign o_apply       = i_boundary & r_pend_full;
  assign cfg.cfg_ready = ~r_pend_full;

  assign o_pend_full = r_pend_full;
  assign o_pend_pos  = r_pend_pos;
  assign o_pend_neg  = r_pend_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_full <= 1'b0;
      r_pend_pos  <= '0;
      r_pend_neg  <= '0;
    end else begin
      if (w_accept) begin
        r_pend_pos  <= cfg.cfg_pos;
        r_pend_neg  <= cfg.cfg_neg;
        r_pend_full <= 1'b1;
      end else if (o_apply) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(w_accept && o_apply));

endmodule

// File: rtl/pwm_gen.sv
// Programmable PWM source: pos cycles high then neg cycles low, repeating.
// New configurations take effect only at period boundaries, so no period is ever cut short.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PwmWidthDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  pwm_if.slave cfg,
  output logic wave_out,
  output logic period_start,
  output logic busy
);

  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  pwm_state_e       r_state;
  pwm_state_e       w_state_d;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_d;
  logic [WIDTH-1:0] r_act_pos;
  logic [WIDTH-1:0] r_act_neg;
  logic             r_wave;
  logic             r_pstart;

  logic [WIDTH-1:0] w_pend_pos;
  logic [WIDTH-1:0] w_pend_neg;
  logic [WIDTH-1:0] w_eff_pos;
  logic [WIDTH-1:0] w_eff_neg;
  logic             w_pend_full;
  logic             w_apply;
  logic             w_boundary;
  logic             w_start;
  logic             w_eff_zero;
  logic             w_wave_d;

  pwm_cfg_buf #(
    .WIDTH(WIDTH)
  ) u_cfg_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (cfg),
    .i_boundary (w_boundary),
    .o_apply    (w_apply),
    .o_pend_full(w_pend_full),
    .o_pend_pos (w_pend_pos),
    .o_pend_neg (w_pend_neg)
  );

  // Config that the next period would run with if a boundary were taken now.
  assign w_eff_pos  = w_pend_full ? w_pend_pos : r_act_pos;
  assign w_eff_neg  = w_pend_full ? w_pend_neg : r_act_neg;
  assign w_eff_zero = (w_eff_pos == '0) && (w_eff_neg == '0);

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_boundary = 1'b0;
    w_start    = 1'b0;

    unique case (r_state)
      StIdle: begin
        // An idle block with en set consumes any pending config even if it is all-zero,
        // so a zero config never wedges the handshake.
        w_boundary = en;
      end
      StHigh: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - CntOne;
        end else if (r_act_neg != '0) begin
          w_state_d = StLow;
          w_cnt_d   = r_act_neg - CntOne;
        end else begin
          w_boundary = 1'b1;
        end
      end
      StLow: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - CntOne;
        end else begin
          w_boundary = 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase

    if (w_boundary) begin
      if (en && !w_eff_zero) begin
        w_start = 1'b1;
      end else begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    end

    if (w_start) begin
      if (w_eff_pos != '0) begin
        w_state_d = StHigh;
        w_cnt_d   = w_eff_pos - CntOne;
      end else begin
        w_state_d = StLow;
        w_cnt_d   = w_eff_neg - CntOne;
      end
    end

    w_wave_d = (w_state_d == StHigh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_act_pos <= '0;
      r_act_neg <= '0;
      r_wave    <= 1'b0;
      r_pstart  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_wave   <= w_wave_d;
      r_pstart <= w_start;
      if (w_apply) begin
        r_act_pos <= w_pend_pos;
        r_act_neg <= w_pend_neg;
      end
    end
  end

  assign wave_out     = r_wave;
  assign period_start = r_pstart;
  assign busy         = (r_state != StIdle);

  assert property (@(posedge clk) disable iff (!rst_n) period_start |-> busy);
  assert property (@(posedge clk) disable iff (!rst_n) !busy |-> !wave_out);

endmodule
